// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute-stage ALU: op codes, FSM states, op-class helpers.
package alu_pkg;

   localparam int unsigned OP_W = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLT    = 5'd5,
      OP_SLTU   = 5'd6,
      OP_SLL    = 5'd7,
      OP_SRL    = 5'd8,
      OP_SRA    = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } alu_state_e;

   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return (op >= OP_MUL) && (op <= OP_REMU);
   endfunction

   function automatic logic is_div(input logic [OP_W-1:0] op);
      return (op >= OP_DIV) && (op <= OP_REMU);
   endfunction

endpackage

// File: rtl/alu_mcycle_if.sv
// Request/result handshake between the issue stage and the multi-cycle ALU.
interface alu_mcycle_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic [OP_W-1:0]  i_op;
   logic [WIDTH-1:0] i_Src_a;
   logic [WIDTH-1:0] i_Src_b;
   logic             i_flush;
   logic             o_valid;
   logic [WIDTH-1:0] o_result;
   logic             o_zero;

   modport master (
      output i_valid, i_op, i_Src_a, i_Src_b, i_flush,
      input  o_ready, o_valid, o_result, o_zero
   );

   modport slave (
      input  i_valid, i_op, i_Src_a, i_Src_b, i_flush,
      output o_ready, o_valid, o_result, o_zero
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign correction applied combinationally on the final registers.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             cnt_zero_c,
   output logic [WIDTH-1:0] result_c
);
   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] hi_q, lo_q, mag_q;
   logic [CNT_W-1:0] cnt_q;
   logic             div_q, neg_q, sel_hi_q;

   logic             a_sgn, b_sgn, a_neg, b_neg, op_div, op_rem, op_hi;
   logic [WIDTH-1:0] mag_a, mag_b;

   // Operand signedness, magnitudes and which half/register holds the answer
   always_comb begin
      a_sgn  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_sgn  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      a_neg  = a_sgn & a[WIDTH-1];
      b_neg  = b_sgn & b[WIDTH-1];
      mag_a  = a_neg ? -a : a;
      mag_b  = b_neg ? -b : b;
      op_div = is_div(op);
      op_rem = (op == OP_REM) || (op == OP_REMU);
      op_hi  = op_rem || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
   end

   logic [WIDTH:0]   sum, shifted, diff;
   logic [WIDTH-1:0] hi_d, lo_d;

   // hi/lo hold {product high, multiplier} or {partial remainder, quotient}
   always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
      shifted = {hi_q, lo_q[WIDTH-1]};
      diff    = shifted - {1'b0, mag_q};
      if (div_q) begin
         if (!diff[WIDTH]) begin
            hi_d = diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = shifted[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_d = sum[WIDTH:1];
         lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   part;

   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = neg_q ? -prod : prod;
      part     = sel_hi_q ? hi_q : lo_q;
      if (div_q) result_c = neg_q ? -part : part;
      else       result_c = sel_hi_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
   end

   assign cnt_zero_c = (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q     <= '0;
         lo_q     <= '0;
         mag_q    <= '0;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         sel_hi_q <= 1'b0;
      end else if (load) begin
         hi_q     <= '0;
         lo_q     <= op_div ? mag_a : mag_b;
         mag_q    <= op_div ? mag_b : mag_a;
         cnt_q    <= CNT_W'(WIDTH - 1);
         div_q    <= op_div;
         neg_q    <= op_rem ? a_neg : (a_neg ^ b_neg);
         sel_hi_q <= op_hi;
      end else if (step) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         if (!cnt_zero_c) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/alu_mcycle.sv
// Handshaked execute-stage ALU: single-cycle RV32I ops, iterative RV32M ops,
// registered result held until the next accepted operation.
module alu_mcycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   alu_mcycle_if.slave  bus
);
   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   alu_state_e       state_q, state_d;
   alu_op_e          op;
   logic [WIDTH-1:0] a, b, base_res, md_res, res_q, res_d, result_q;
   logic [SHAMT_W-1:0] shamt;
   logic             div_zero, div_ovf, special;
   logic             load, step, res_we, cnt_zero;
   logic             valid_q, ready_q, zero_q;

   // Base ops plus divide special cases, evaluated on the live request
   always_comb begin
      op       = alu_op_e'(bus.i_op);
      a        = bus.i_Src_a;
      b        = bus.i_Src_b;
      shamt    = b[SHAMT_W-1:0];
      div_zero = (b == '0);
      div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      special  = 1'b0;
      base_res = '0;
      case (op)
         OP_ADD:  base_res = a + b;
         OP_SUB:  base_res = a - b;
         OP_AND:  base_res = a & b;
         OP_OR:   base_res = a | b;
         OP_XOR:  base_res = a ^ b;
         OP_SLT:  base_res = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: base_res = WIDTH'(a < b);
         OP_SLL:  base_res = a << shamt;
         OP_SRL:  base_res = a >> shamt;
         OP_SRA:  base_res = WIDTH'($signed(a) >>> shamt);
         OP_DIV: begin
            special  = div_zero || div_ovf;
            base_res = div_zero ? '1 : a;
         end
         OP_DIVU: begin
            special  = div_zero;
            base_res = '1;
         end
         OP_REM: begin
            special  = div_zero || div_ovf;
            base_res = div_zero ? a : '0;
         end
         OP_REMU: begin
            special  = div_zero;
            base_res = a;
         end
         default: base_res = '0;
      endcase
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk        (i_clk),
      .rst        (i_rst),
      .load       (load),
      .step       (step),
      .op         (bus.i_op),
      .a          (bus.i_Src_a),
      .b          (bus.i_Src_b),
      .cnt_zero_c (cnt_zero),
      .result_c   (md_res)
   );

   // Next state, iterator control and pending-result write
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      res_we  = 1'b0;
      res_d   = base_res;
      case (state_q)
         IDLE: begin
            if (bus.i_valid && !bus.i_flush) begin
               if (is_muldiv(bus.i_op) && !special) begin
                  load    = 1'b1;
                  state_d = CALC;
               end else begin
                  res_we  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         CALC: begin
            if (bus.i_flush) begin
               state_d = IDLE;
            end else begin
               step = 1'b1;
               if (cnt_zero) state_d = FIX;
            end
         end
         FIX: begin
            if (bus.i_flush) begin
               state_d = IDLE;
            end else begin
               res_d   = md_res;
               res_we  = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Result is published on the edge that leaves DONE
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         res_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         valid_q <= (state_q == DONE);
         ready_q <= (state_d == IDLE);
         if (res_we) res_q <= res_d;
         if (state_q == DONE) begin
            result_q <= res_q;
            zero_q   <= (res_q == '0);
         end
      end
   end

   assign bus.o_valid  = valid_q;
   assign bus.o_ready  = ready_q;
   assign bus.o_result = result_q;
   assign bus.o_zero   = zero_q;

endmodule

// File: tb/tb_alu_mcycle.sv
// Directed bench for alu_mcycle: latency/ready model checked every cycle,
// plus literal per-operation expectations.
module tb_alu_mcycle;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   alu_mcycle_if #(.WIDTH(W)) bus();

   alu_mcycle #(.WIDTH(W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Architectural result of one operation
   function automatic logic [31:0] ref_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         OP_SRA:  return 32'(sa >>> b[4:0]);
         OP_MUL: begin
            p = 64'(longint'(sa) * longint'(sb));
            return p[31:0];
         end
         OP_MULH: begin
            p = 64'(longint'(sa) * longint'(sb));
            return p[63:32];
         end
         OP_MULHSU: begin
            p = 64'(longint'(sa) * longint'({32'b0, b}));
            return p[63:32];
         end
         OP_MULHU: begin
            p = {32'b0, a} * {32'b0, b};
            return p[63:32];
         end
         OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         OP_DIVU: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         OP_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         OP_REMU: begin
            if (b == 32'd0) return a;
            return a % b;
         end
         default: return 32'd0;
      endcase
   endfunction

   // Cycles from acceptance edge to the o_valid edge
   function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic fast;
      if (op < 5'd10 || op > 5'd17) return 1;
      fast = (op >= 5'd14) && (b == 32'd0 ||
             ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      return fast ? 1 : W + 2;
   endfunction

   logic        m_ready  = 1'b1;
   logic        m_valid  = 1'b0;
   logic        m_zero   = 1'b1;
   logic [31:0] m_result = 32'd0;
   logic [31:0] m_pend   = 32'd0;
   int          m_remain = 0;

   // Behavioural model: countdown to the result pulse, cancelled by a flush before the last cycle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ready  <= 1'b1;
         m_valid  <= 1'b0;
         m_zero   <= 1'b1;
         m_result <= 32'd0;
         m_remain <= 0;
      end else begin
         m_valid <= 1'b0;
         if (m_remain == 0) begin
            if (bus.i_valid && !bus.i_flush) begin
               m_remain <= ref_lat(bus.i_op, bus.i_Src_a, bus.i_Src_b);
               m_pend   <= ref_fn(bus.i_op, bus.i_Src_a, bus.i_Src_b);
               m_ready  <= 1'b0;
            end
         end else if (m_remain == 1) begin
            m_remain <= 0;
            m_valid  <= 1'b1;
            m_result <= m_pend;
            m_zero   <= (m_pend == 32'd0);
            m_ready  <= 1'b1;
         end else if (bus.i_flush) begin
            m_remain <= 0;
            m_ready  <= 1'b1;
         end else begin
            m_remain <= m_remain - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("cmp_valid",  32'(bus.o_valid), 32'(m_valid));
         check("cmp_ready",  32'(bus.o_ready), 32'(m_ready));
         check("cmp_result", bus.o_result, m_result);
         check("cmp_zero",   32'(bus.o_zero), 32'(m_zero));
      end
   end

   // Wait for ready, present one request, then scramble the operand lines
   task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(bus.o_ready), 32'd1);
      bus.i_valid = 1'b1;
      bus.i_op    = op;
      bus.i_Src_a = a;
      bus.i_Src_b = b;
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_Src_a = $urandom;
      bus.i_Src_b = $urandom;
      bus.i_op    = 5'($urandom_range(0, 17));
   endtask

   task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input string name);
      int   k;
      logic seen;
      seen = 1'b0;
      start_op(op, a, b);
      for (k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (bus.o_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_seen"}, 32'(seen), 32'd1);
      check({name, "_lat"}, 32'(k), 32'(lat));
      check({name, "_res"}, bus.o_result, exp);
      check({name, "_zero"}, 32'(bus.o_zero), 32'(exp == 32'd0));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      int stray;
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      bus.i_op    = 5'd0;
      bus.i_Src_a = 32'd0;
      bus.i_Src_b = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready",  32'(bus.o_ready), 32'd1);
      check("rst_valid",  32'(bus.o_valid), 32'd0);
      check("rst_result", bus.o_result, 32'd0);
      check("rst_zero",   32'(bus.o_zero), 32'd1);

      run(OP_ADD,  32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1, "add_wrap");
      run(OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1, "slt");
      run(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "sltu");
      run(OP_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 1, "sra");
      run(OP_SLL,  32'd1, 32'd31, 32'h8000_0000, 1, "sll");
      run(OP_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000, 1, "srl");
      run(OP_XOR,  32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1, "xor");
      run(5'd20,   32'd5, 32'd6, 32'd0, 1, "reserved");

      run(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
      run(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
      run(OP_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
      run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");

      run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");
      run(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");
      run(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu");
      run(OP_REMU, 32'd100, 32'd7, 32'd2, 34, "remu");
      run(OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
      run(OP_REMU, 32'd100, 32'd0, 32'd100, 1, "remu_by0");
      run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

      // Flush in the middle of a divide
      run(OP_SUB, 32'd10, 32'd3, 32'd7, 1, "sub");
      start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (9) @(negedge clk);
      bus.i_flush = 1'b1;
      @(posedge clk);
      #1;
      check("flush_ready", 32'(bus.o_ready), 32'd1);
      check("flush_valid", 32'(bus.o_valid), 32'd0);
      check("flush_hold",  bus.o_result, 32'd7);
      @(negedge clk);
      bus.i_flush = 1'b0;
      stray = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.o_valid) stray++;
      end
      check("flush_no_pulse", 32'(stray), 32'd0);
      run(OP_ADD, 32'd2, 32'd3, 32'd5, 1, "add_after_flush");

      // Flush in IDLE blocks acceptance
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_flush = 1'b1;
      bus.i_op    = OP_ADD;
      bus.i_Src_a = 32'd1;
      bus.i_Src_b = 32'd1;
      @(posedge clk);
      #1;
      check("idle_flush_ready", 32'(bus.o_ready), 32'd1);
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      @(posedge clk);
      #1;
      check("idle_flush_valid", 32'(bus.o_valid), 32'd0);
      check("idle_flush_hold",  bus.o_result, 32'd5);

      // Asynchronous reset during a multiply
      start_op(OP_MUL, 32'd7, 32'd3);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_ready",  32'(bus.o_ready), 32'd1);
      check("mid_rst_valid",  32'(bus.o_valid), 32'd0);
      check("mid_rst_result", bus.o_result, 32'd0);
      check("mid_rst_zero",   32'(bus.o_zero), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 34, "mulhu_after_rst");

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
